// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
// ---------------------------------------------------------------------------
// bsg_front_side_bus_hop_out_no_fc
//
// Egress stage of a front-side-bus hop. The pass-through bus stream has no
// flow control, so it always wins arbitration for the output register. Local
// beats wait in a small FIFO, and the local node sees ready/valid
// backpressure. A saturating counter reports how long the FIFO head has been
// starved by bus traffic.
//
// Ports:
//   clk_i              clock
//   reset_i            synchronous, active-high reset
//   v_i / data_i       pass-through beat from the upstream hop (never stalled)
//   local_v_i          local beat valid
//   local_data_i       local beat data
//   local_ready_o      local FIFO can accept a beat this cycle
//   v_o / data_o       registered beat toward the next hop (data_o is
//                      meaningful only while v_o=1)
//   local_stall_cnt_o  consecutive cycles the FIFO head has been blocked
// ---------------------------------------------------------------------------
module bsg_front_side_bus_hop_out_no_fc #(
  parameter int width_p           = 32,
  parameter int els_p             = 2,
  parameter int stall_cnt_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         local_v_i,
  input  logic [width_p-1:0]           local_data_i,
  output logic                         local_ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  output logic [stall_cnt_width_p-1:0] local_stall_cnt_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;

  logic [width_p-1:0]           r_mem [els_p];
  logic [ptr_w_lp-1:0]          r_wptr;
  logic [ptr_w_lp-1:0]          r_rptr;
  logic                         r_v;
  logic [width_p-1:0]           r_data;
  logic [stall_cnt_width_p-1:0] r_stall_cnt;

  logic                         w_empty;
  logic                         w_full;
  logic                         w_enq;
  logic                         w_deq;
  logic                         w_load;
  logic [width_p-1:0]           w_load_data;
  logic                         w_stall_sat;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[lg_els_lp-1:0] == r_rptr[lg_els_lp-1:0]) &&
                   (r_wptr[lg_els_lp] != r_rptr[lg_els_lp]);

  // Ready deliberately ignores a same-cycle pop, keeping it off the bus
  // valid path.
  assign local_ready_o = ~w_full & ~reset_i;
  assign w_enq         = local_v_i & local_ready_o;

  assign w_stall_sat   = &r_stall_cnt;

  // Fixed-priority arbitration: bus beat first, then FIFO head.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_deq       = 1'b0;
    w_load      = 1'b0;
    w_load_data = data_i;
    if (v_i) begin
      w_load      = 1'b1;
    end else if (!w_empty) begin
      w_deq       = 1'b1;
      w_load      = 1'b1;
      w_load_data = r_mem[r_rptr[lg_els_lp-1:0]];
    end
  end

  // Control state: pointers, output valid and starvation counter.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_v         <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + ptr_w_lp'(1);
      if (w_deq) r_rptr <= r_rptr + ptr_w_lp'(1);
      r_v <= w_load;
      // Non-empty without a pop can only mean the bus held the slot.
      if (w_deq || w_empty) begin
        r_stall_cnt <= '0;
      end else if (!w_stall_sat) begin
        r_stall_cnt <= r_stall_cnt + stall_cnt_width_p'(1);
      end
    end
  end

  // Datapath storage: FIFO array and output data register.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; the reset pointers make stale entries
    // unreachable and data_o is qualified by v_o.
    if (w_enq)  r_mem[r_wptr[lg_els_lp-1:0]] <= local_data_i;
    if (w_load) r_data <= w_load_data;
  end

  assign v_o               = r_v;
  assign data_o            = r_data;
  assign local_stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_no_fc.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_front_side_bus_hop_out_no_fc.
// A queue-based reference model predicts the output register, the local
// ready and the starvation counter; a negedge process compares the DUT
// against it every cycle. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_bsg_front_side_bus_hop_out_no_fc;

  localparam int W    = 32;
  localparam int ELS  = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset_i;
  logic          v_i;
  logic [W-1:0]  data_i;
  logic          local_v_i;
  logic [W-1:0]  local_data_i;
  logic          local_ready_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] local_stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  bsg_front_side_bus_hop_out_no_fc #(
    .width_p(W), .els_p(ELS), .stall_cnt_width_p(CW)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .v_i               (v_i),
    .data_i            (data_i),
    .local_v_i         (local_v_i),
    .local_data_i      (local_data_i),
    .local_ready_o     (local_ready_o),
    .v_o               (v_o),
    .data_o            (data_o),
    .local_stall_cnt_o (local_stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_q[$];
  bit           m_live = 0;
  bit           m_v    = 0;
  logic [W-1:0] m_d    = '0;
  int           m_cnt  = 0;

  initial forever begin
    @(posedge clk);
    if (reset_i) begin
      m_q.delete();
      m_v   = 0;
      m_cnt = 0;
      m_live = 1;
    end else if (m_live) begin
      bit had_items;
      bit can_take;
      had_items = (m_q.size() > 0);
      can_take  = (m_q.size() < ELS);
      if (v_i) begin
        m_v = 1; m_d = data_i;
      end else if (had_items) begin
        m_v = 1; m_d = m_q.pop_front();
      end else begin
        m_v = 0;
      end
      if (v_i && had_items) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      else                  m_cnt = 0;
      if (local_v_i && can_take) m_q.push_back(local_data_i);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("v_o", v_o, m_v);
      if (m_v) check("data_o", data_o, m_d);
      check("stall_cnt", local_stall_cnt_o, m_cnt);
      check("local_ready", local_ready_o, !reset_i && (m_q.size() < ELS));
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs shortly after an edge, report whether the local beat is
  // accepted at the coming edge, and return 1 time unit after that edge.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d,
                      input logic lv, input logic [W-1:0] ld, output logic acc);
    reset_i = rst; v_i = v; data_i = d; local_v_i = lv; local_data_i = ld;
    #1;
    acc = lv & local_ready_o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic         acc;
    logic [W-1:0] nxt;
    reset_i = 1; v_i = 0; data_i = '0; local_v_i = 0; local_data_i = '0;

    // Reset
    step(1, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, acc);
    check("rst_v_o", v_o, 0);
    check("rst_cnt", local_stall_cnt_o, 0);
    check("rst_ready", local_ready_o, 0);
    step(0, 0, 0, 0, 0, acc);
    check("post_rst_ready", local_ready_o, 1);

    // Single bus beat: visible the next cycle only
    step(0, 0, 0, 0, 0, acc);
    step(0, 1, 32'hA5A5_0001, 0, 0, acc);
    check("bus_v", v_o, 1);
    check("bus_d", data_o, 32'hA5A5_0001);
    step(0, 0, 0, 0, 0, acc);
    check("bus_gone", v_o, 0);

    // Single local beat with bus idle: two-cycle latency
    step(0, 0, 0, 1, 32'h0000_0011, acc);
    check("loc_enq", acc, 1);
    check("loc_not_yet", v_o, 0);
    step(0, 0, 0, 0, 0, acc);
    check("loc_v", v_o, 1);
    check("loc_d", data_o, 32'h0000_0011);
    step(0, 0, 0, 0, 0, acc);
    check("loc_gone", v_o, 0);

    // Starvation with a full FIFO; beat 3 is held by the source
    step(0, 1, 32'hB000_0000, 1, 1, acc);
    check("st_cnt0", local_stall_cnt_o, 0);
    check("st_ready1", local_ready_o, 1);
    step(0, 1, 32'hB000_0001, 1, 2, acc);
    check("st_cnt1", local_stall_cnt_o, 1);
    check("st_full", local_ready_o, 0);
    step(0, 1, 32'hB000_0002, 1, 3, acc);
    check("st_blocked", acc, 0);
    check("st_cnt2", local_stall_cnt_o, 2);
    step(0, 1, 32'hB000_0003, 1, 3, acc);
    check("st_cnt3", local_stall_cnt_o, 3);
    check("st_bus_d", data_o, 32'hB000_0003);
    step(0, 0, 0, 1, 3, acc);
    check("st_out1", data_o, 1);
    check("st_cnt_clr", local_stall_cnt_o, 0);
    step(0, 0, 0, 1, 3, acc);
    check("st_enq3", acc, 1);
    check("st_out2", data_o, 2);
    step(0, 0, 0, 0, 0, acc);
    check("st_v3", v_o, 1);
    check("st_out3", data_o, 3);
    step(0, 0, 0, 0, 0, acc);
    check("st_drained", v_o, 0);

    // Long bus stream with a pending local beat: counter saturates
    for (int i = 0; i < 300; i++)
      step(0, 1, 32'hC000_0000 + W'(i), (i == 0), 32'h0000_0077, acc);
    check("sat_cnt", local_stall_cnt_o, CMAX);
    check("sat_bus_d", data_o, 32'hC000_012B);
    step(0, 0, 0, 0, 0, acc);
    check("sat_pop", data_o, 32'h0000_0077);
    check("sat_clr", local_stall_cnt_o, 0);
    step(0, 0, 0, 0, 0, acc);

    // Alternating bus/idle with local traffic always offered
    nxt = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 32'hD000_0000 + W'(i), 1, nxt, acc);
      if (acc) nxt++;
    end
    for (int i = 0; i < 10; i++) begin
      step(0, (i % 2 == 1), 32'hE000_0000 + W'(i), 1, nxt, acc);
      if (acc) nxt++;
      check("alt_v", v_o, 1);
      if (i % 2 == 1) check("alt_bus_d", data_o, 32'hE000_0000 + W'(i));
      else            check("alt_loc_msb", data_o[31:8], 24'h000001);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, acc);
    check("alt_drained", v_o, 0);

    // Fill FIFO, then reset mid-operation
    step(0, 1, 32'hF000_0000, 1, 32'hDEAD_0001, acc);
    step(0, 1, 32'hF000_0001, 1, 32'hDEAD_0002, acc);
    check("pre_rst_full", local_ready_o, 0);
    step(1, 0, 0, 0, 0, acc);
    check("mid_rst_v", v_o, 0);
    check("mid_rst_cnt", local_stall_cnt_o, 0);
    step(0, 0, 0, 0, 0, acc);
    check("mid_rst_ready", local_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, acc);
      check("no_stale_beat", v_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
